// File: rtl/mem_access_pkg.sv
// Shared types, constants and helpers for the mem_access pipeline stage.
// Opcode, access-size and exception codes match those used by execute and writeback.
package mem_access_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned ExWidth      = 4;

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  localparam logic [2:0] F3Byte  = 3'd0;
  localparam logic [2:0] F3Half  = 3'd1;
  localparam logic [2:0] F3Word  = 3'd2;
  localparam logic [2:0] F3ByteU = 3'd4;
  localparam logic [2:0] F3HalfU = 3'd5;

  localparam logic [ExWidth-1:0] ExLoadMisalign  = 4'd4;
  localparam logic [ExWidth-1:0] ExLoadFault     = 4'd5;
  localparam logic [ExWidth-1:0] ExStoreMisalign = 4'd6;
  localparam logic [ExWidth-1:0] ExStoreFault    = 4'd7;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Registered record handed to writeback.
  typedef struct packed {
    logic [4:0]              opcode;
    logic                    nop;
    logic [DataWidth-1:0]    result;
    logic [RegAddrWidth-1:0] rd;
    logic                    exc_valid;
    logic [ExWidth-1:0]      exc;
    logic                    halt;
  } wb_t;

  // Memory access latched at acceptance and held for the whole BUSY phase.
  typedef struct packed {
    logic                    we;
    logic [AddrWidth-1:0]    addr;
    logic [1:0]              off;
    logic [2:0]              funct3;
    logic [3:0]              be;
    logic [DataWidth-1:0]    wdata;
    logic [4:0]              opcode;
    logic [RegAddrWidth-1:0] rd;
  } acc_t;

  function automatic size_e decode_size(logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    case (size)
      SzHalf:  return off[0];
      SzWord:  return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] force_align(size_e size, logic [1:0] off);
    case (size)
      SzHalf:  return {off[1], 1'b0};
      SzWord:  return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(size_e size, logic [1:0] off);
    case (size)
      SzByte:  return 4'b0001 << off;
      SzHalf:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] replicate(size_e size, logic [DataWidth-1:0] d);
    case (size)
      SzByte:  return {4{d[7:0]}};
      SzHalf:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: selects the addressed lane of a memory word and
// sign- or zero-extends it according to the load size code.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [DataWidth-1:0] rdata,
  input  logic [1:0]           offset,
  input  logic [2:0]           funct3,
  output logic [DataWidth-1:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3Byte:  data = {{24{lane_byte[7]}}, lane_byte};
      F3Half:  data = {{16{lane_half[15]}}, lane_half};
      F3ByteU: data = {24'b0, lane_byte};
      F3HalfU: data = {16'b0, lane_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: LOAD/STORE over a req/ack data port, pass-through otherwise.
// Build option MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [4:0]              in_opcode,
  input  logic [2:0]              in_funct3,
  input  logic                    in_nop,
  input  logic [DataWidth-1:0]    in_result,
  input  logic [DataWidth-1:0]    in_store_data,
  input  logic [RegAddrWidth-1:0] in_rd_addr,
  input  logic                    in_exception_valid,
  input  logic [ExWidth-1:0]      in_exception,
  input  logic                    in_halt,
  output logic                    stall_out,
  output logic [4:0]              opcode,
  output logic                    nop_instr,
  output logic [DataWidth-1:0]    result,
  output logic [RegAddrWidth-1:0] rd_addr,
  output logic                    exception_valid,
  output logic [ExWidth-1:0]      exception,
  output logic                    halt_out,
  output logic                    pipeline_valid,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [AddrWidth-1:0]    dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [DataWidth-1:0]    dmem_wdata,
  input  logic [DataWidth-1:0]    dmem_rdata,
  input  logic                    dmem_ack
);

  localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  acc_t                 acc_q, acc_d;
  wb_t                  wb_q, wb_d;
  logic                 pv_q, pv_d;

  logic                 is_load, is_store, is_mem, pass_through;
  size_e                size;
  logic                 misaligned;
  logic [1:0]           eff_off;
  logic [DataWidth-1:0] load_data;

  assign is_load      = (in_opcode == OpLoad);
  assign is_store     = (in_opcode == OpStore);
  assign is_mem       = is_load | is_store;
  assign pass_through = !is_mem || in_nop || in_exception_valid || in_halt;
  assign size         = decode_size(in_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(size, in_result[1:0]);
  assign eff_off    = in_result[1:0];
`else
  // Without the trap, low address bits below the access size are simply ignored.
  assign misaligned = 1'b0;
  assign eff_off    = force_align(size, in_result[1:0]);
`endif

  mem_access_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (acc_q.off),
    .funct3 (acc_q.funct3),
    .data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wb_d    = wb_q;
    pv_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (pass_through || misaligned) begin
            wb_d.opcode    = in_opcode;
            wb_d.nop       = in_nop;
            wb_d.result    = in_result;
            wb_d.rd        = in_rd_addr;
            wb_d.exc_valid = in_exception_valid;
            wb_d.exc       = in_exception;
            wb_d.halt      = in_halt;
            pv_d           = 1'b1;
            if (!pass_through) begin
              wb_d.exc_valid = 1'b1;
              wb_d.exc       = is_load ? ExLoadMisalign : ExStoreMisalign;
            end
          end else begin
            acc_d.we     = is_store;
            acc_d.addr   = in_result;
            acc_d.off    = eff_off;
            acc_d.funct3 = in_funct3;
            acc_d.be     = byte_enable(size, eff_off);
            acc_d.wdata  = replicate(size, in_store_data);
            acc_d.opcode = in_opcode;
            acc_d.rd     = in_rd_addr;
            cnt_d        = '0;
            state_d      = StBusy;
          end
        end
      end
      StBusy: begin
        if (dmem_ack || (cnt_q == TimeoutLast)) begin
          wb_d.opcode    = acc_q.opcode;
          wb_d.nop       = 1'b0;
          wb_d.rd        = acc_q.rd;
          wb_d.halt      = 1'b0;
          wb_d.result    = acc_q.addr;
          wb_d.exc_valid = 1'b0;
          wb_d.exc       = '0;
          pv_d           = 1'b1;
          cnt_d          = '0;
          state_d        = StIdle;
          // An ack in the timeout cycle still completes the access normally.
          if (dmem_ack) begin
            if (!acc_q.we) begin
              wb_d.result = load_data;
            end
          end else begin
            wb_d.exc_valid = 1'b1;
            wb_d.exc       = acc_q.we ? ExStoreFault : ExLoadFault;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      wb_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
      pv_q    <= pv_d;
    end
  end

  assign stall_out       = (state_q == StBusy);
  assign dmem_req        = (state_q == StBusy);
  assign dmem_we         = acc_q.we;
  assign dmem_addr       = {acc_q.addr[AddrWidth-1:2], 2'b00};
  assign dmem_be         = acc_q.be;
  assign dmem_wdata      = acc_q.wdata;

  assign opcode          = wb_q.opcode;
  assign nop_instr       = wb_q.nop;
  assign result          = wb_q.result;
  assign rd_addr         = wb_q.rd;
  assign exception_valid = wb_q.exc_valid;
  assign exception       = wb_q.exc;
  assign halt_out        = wb_q.halt;
  assign pipeline_valid  = pv_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized instructions against a byte-level
// reference model, with a scripted memory responder and a retirement monitor.
module tb_mem_access;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_nop;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd_addr;
  logic        in_exception_valid;
  logic [3:0]  in_exception;
  logic        in_halt;
  logic        stall_out;
  logic [4:0]  opcode;
  logic        nop_instr;
  logic [31:0] result;
  logic [4:0]  rd_addr;
  logic        exception_valid;
  logic [3:0]  exception;
  logic        halt_out;
  logic        pipeline_valid;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  mem_access #(.BUS_TIMEOUT(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_opcode          (in_opcode),
    .in_funct3          (in_funct3),
    .in_nop             (in_nop),
    .in_result          (in_result),
    .in_store_data      (in_store_data),
    .in_rd_addr         (in_rd_addr),
    .in_exception_valid (in_exception_valid),
    .in_exception       (in_exception),
    .in_halt            (in_halt),
    .stall_out          (stall_out),
    .opcode             (opcode),
    .nop_instr          (nop_instr),
    .result             (result),
    .rd_addr            (rd_addr),
    .exception_valid    (exception_valid),
    .exception          (exception),
    .halt_out           (halt_out),
    .pipeline_valid     (pipeline_valid),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opcode;
    logic        nop;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        excv;
    logic [3:0]  exc;
    logic        halt;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cycle;
  } mem_t;

  exp_t eq[$];
  mem_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: decides the whole transaction (memory request and retirement) up front.
  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic nop,
                       input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd,
                       input logic excv, input logic [3:0] exc, input logic halt,
                       input logic [31:0] rdata, input int ack_cycle, input bit retires);
    exp_t        e;
    mem_t        m;
    bit          is_load;
    bit          trapped;
    int          size;
    int          off;
    int          w;
    logic [3:0]  mask;
    logic [31:0] v;
    e.opcode = op; e.nop = nop; e.result = res; e.rd = rd;
    e.excv = excv; e.exc = exc; e.halt = halt;
    is_load = (op == 5'b00000);
    if ((is_load || op == 5'b01000) && !nop && !excv && !halt) begin
      size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off     = int'(res[1:0]);
      trapped = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (off % size != 0) begin
        trapped = 1'b1;
        e.excv  = 1'b1;
        e.exc   = is_load ? 4'd4 : 4'd6;
      end
`else
      off = off - (off % size);
`endif
      if (!trapped) begin
        mask        = (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
        m.we        = !is_load;
        m.addr      = res & ~32'h3;
        m.be        = mask << off;
        m.wdata     = (size == 1) ? {4{sdata[7:0]}} : (size == 2) ? {2{sdata[15:0]}} : sdata;
        m.rdata     = rdata;
        m.ack_cycle = ack_cycle;
        mq.push_back(m);
        if (ack_cycle > TO) begin
          e.excv = 1'b1;
          e.exc  = is_load ? 4'd5 : 4'd7;
        end else if (is_load) begin
          v = rdata >> (8 * off);
          if (size == 1) v = f3[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
          else if (size == 2) v = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          e.result = v;
        end
      end
    end
    if (retires) eq.push_back(e);

    w = 0;
    while (stall_out !== 1'b0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      n_vec++; n_err++;
      $display("FAIL stall_release: stall_out still %b after 50 cycles, expected 0", stall_out);
    end
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_nop = nop; in_result = res;
    in_store_data = sdata; in_rd_addr = rd; in_exception_valid = excv;
    in_exception = exc; in_halt = halt;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Memory responder: checks the request on its first cycle and acks on the scripted cycle.
  initial begin
    mem_t cur;
    int   cyc;
    cyc = 0;
    cur.ack_cycle = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dmem_req === 1'b1) begin
        cyc++;
        if (cyc == 1) begin
          if (mq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_req: dmem_req=1 at addr %h, expected no request", dmem_addr);
            cur.ack_cycle = 1;
          end else begin
            cur = mq.pop_front();
            check("dmem_we", dmem_we, cur.we);
            check("dmem_addr", dmem_addr, cur.addr);
            check("dmem_be", dmem_be, cur.be);
            if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
            check("stall_out_busy", stall_out, 1'b1);
            dmem_rdata = cur.rdata;
          end
        end
        dmem_ack = (cyc == cur.ack_cycle);
      end else begin
        cyc = 0;
        dmem_ack = 1'b0;
      end
    end
  end

  // Retirement monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && pipeline_valid === 1'b1) begin
        if (eq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_retire: pipeline_valid=1 result %h, expected no retire", result);
        end else begin
          e = eq.pop_front();
          check("opcode", opcode, e.opcode);
          check("nop_instr", nop_instr, e.nop);
          check("result", result, e.result);
          check("rd_addr", rd_addr, e.rd);
          check("exception_valid", exception_valid, e.excv);
          check("exception", exception, e.exc);
          check("halt_out", halt_out, e.halt);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] load_f3 [5];
    logic [4:0] op;
    logic [2:0] f3;
    int         r;
    int         w;
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_nop = 1'b0;
    in_result = '0; in_store_data = '0; in_rd_addr = '0; in_exception_valid = 1'b0;
    in_exception = '0; in_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pipeline_valid", pipeline_valid, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_stall_out", stall_out, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_exception_valid", exception_valid, 1'b0);
    check("rst_rd_addr", rd_addr, 5'd0);
    check("rst_dmem_be", dmem_be, 4'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD passes through with one cycle of latency.
    issue(5'b01100, 3'd0, 1'b0, 32'h12, 32'h0, 5'd5, 1'b0, 4'd0, 1'b0, 32'h0, 1, 1'b1);
    check("alu_latency", pipeline_valid, 1'b1);
    // SW acked on the third request cycle.
    issue(5'b01000, 3'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 4'd0, 1'b0, 32'h0, 3, 1'b1);
    // LB / LBU on the top lane.
    issue(5'b00000, 3'd0, 1'b0, 32'h103, 32'h0, 5'd7, 1'b0, 4'd0, 1'b0, 32'h80FFFF7F, 1, 1'b1);
    issue(5'b00000, 3'd4, 1'b0, 32'h103, 32'h0, 5'd8, 1'b0, 4'd0, 1'b0, 32'h80FFFF7F, 1, 1'b1);
    // Misaligned half.
    issue(5'b00000, 3'd1, 1'b0, 32'h101, 32'h0, 5'd9, 1'b0, 4'd0, 1'b0, 32'h1234ABCD, 2, 1'b1);
    // LW timeout, then ack exactly on the last allowed cycle.
    issue(5'b00000, 3'd2, 1'b0, 32'h200, 32'h0, 5'd3, 1'b0, 4'd0, 1'b0, 32'h55AA55AA, 100, 1'b1);
    issue(5'b00000, 3'd2, 1'b0, 32'h204, 32'h0, 5'd4, 1'b0, 4'd0, 1'b0, 32'hCAFEF00D, TO, 1'b1);

    // Reset in the middle of an access drops the instruction.
    issue(5'b00000, 3'd2, 1'b0, 32'h300, 32'h0, 5'd6, 1'b0, 4'd0, 1'b0, 32'h0, 100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_dmem_req", dmem_req, 1'b0);
    check("midrst_stall_out", stall_out, 1'b0);
    check("midrst_pipeline_valid", pipeline_valid, 1'b0);
    reset = 1'b1;
    issue(5'b00100, 3'd0, 1'b0, 32'hA5A5_0001, 32'h0, 5'd11, 1'b0, 4'd0, 1'b0, 32'h0, 1, 1'b1);

    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        op = (r == 0) ? 5'b01100 : 5'b00100;
        issue(op, 3'($urandom), 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 4'd0, 1'b0,
              32'h0, 1, 1'b1);
      end else if (r == 2) begin
        op = ($urandom_range(0, 1) == 1) ? 5'b00000 : 5'b01000;
        w  = $urandom_range(0, 2);
        issue(op, 3'd2, w == 0, $urandom, $urandom, 5'($urandom), w == 1, 4'($urandom),
              w == 2, 32'h0, 1, 1'b1);
      end else if (r <= 6) begin
        f3 = load_f3[$urandom_range(0, 4)];
        issue(5'b00000, f3, 1'b0, $urandom, 32'h0, 5'($urandom), 1'b0, 4'd0, 1'b0, $urandom,
              $urandom_range(1, 10), 1'b1);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        issue(5'b01000, f3, 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 4'd0, 1'b0, 32'h0,
              $urandom_range(1, 10), 1'b1);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    w = 0;
    while ((eq.size() != 0 || mq.size() != 0) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_retire_queue", eq.size(), 0);
    check("drain_mem_queue", mq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
